// File: rtl/i2c_target_regfile_if.sv
// rtl/i2c_target_regfile_if.sv - I2C pins and local register port of i2c_target_regfile
interface i2c_target_regfile_if #(
  parameter int PW = 4
) ();
  logic          scl;
  logic          sda_in;
  logic          sda_oe;
  logic          host_we;
  logic [PW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic [7:0]    host_rdata;
  logic          wr_strobe;
  logic [PW-1:0] wr_addr;
  logic          busy;

  modport slave (
    input  scl, sda_in, host_we, host_addr, host_wdata,
    output sda_oe, host_rdata, wr_strobe, wr_addr, busy
  );

  modport master (
    output scl, sda_in, host_we, host_addr, host_wdata,
    input  sda_oe, host_rdata, wr_strobe, wr_addr, busy
  );
endinterface

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing NREG 8-bit registers with an auto-incrementing pointer
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h27,
  parameter int         NREG     = 16,
  parameter int         SYNC     = 2
) (
  input  logic                clk,
  input  logic                rst,
  i2c_target_regfile_if.slave bus
);
  localparam int PW = $clog2(NREG);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic [SYNC-1:0] scl_sync_q, sda_sync_q;
  logic            scl_prev_q, sda_prev_q;
  logic            scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rw_q, rw_d;
  logic            phase_q, phase_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            wr_strobe_q, wr_strobe_d;
  logic [PW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      regs_q [NREG];

  logic [7:0]      byte_in;
  logic [7:0]      rd_byte;
  logic [PW-1:0]   ptr_inc;
  logic            host_ok;

  assign scl_s     = scl_sync_q[SYNC-1];
  assign sda_s     = sda_sync_q[SYNC-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign byte_in = {shift_q[6:0], sda_s};
  assign rd_byte = regs_q[ptr_q];
  assign ptr_inc = (ptr_q == PW'(NREG - 1)) ? '0 : ptr_q + 1'b1;
  assign host_ok = (32'(bus.host_addr) < NREG);

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      phase_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC-2:0], bus.scl};
      sda_sync_q  <= {sda_sync_q[SYNC-2:0], bus.sda_in};
      scl_prev_q  <= scl_s;
      sda_prev_q  <= sda_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      phase_q     <= phase_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  // phase_q: in *_ACK states, set once the ACK is on the bus; in RDATA, a reload is pending
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    phase_d     = phase_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    if (start_det || stop_det) begin
      state_d   = start_det ? ADDR : IDLE;
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              phase_d = 1'b0;
              if (state_q == ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_d = ADDR_ACK;
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == PTR) begin
                ptr_d   = PW'({24'd0, byte_in} % NREG);
                state_d = PTR_ACK;
              end else begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                ptr_d       = ptr_inc;
                state_d     = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d  = 1'b1;
              sda_oe_d = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              sda_oe_d  = 1'b0;
              if (state_q == ADDR_ACK && rw_q) begin
                state_d  = RDATA;
                shift_d  = rd_byte;
                sda_oe_d = ~rd_byte[7];
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (phase_q) begin
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
              phase_d  = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], shift_q[7]};
              sda_oe_d = ~shift_q[6];
            end
          end
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = RDATA_ACK;
          end
        end
        RDATA_ACK: begin
          if (scl_fall && !phase_q) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b1;
          end else if (scl_rise && phase_q) begin
            if (sda_s) begin
              state_d = IGNORE;
              phase_d = 1'b0;
            end else begin
              ptr_d     = ptr_inc;
              state_d   = RDATA;
              bit_cnt_d = 3'd0;
            end
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  // The I2C write comes last so it wins a same-index collision with the host
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
    end else begin
      if (bus.host_we && host_ok) regs_q[bus.host_addr] <= bus.host_wdata;
      if (wr_strobe_d) regs_q[wr_addr_d] <= byte_in;
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.busy       = busy_q;
  assign bus.wr_strobe  = wr_strobe_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.host_rdata = host_ok ? regs_q[bus.host_addr] : 8'h00;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - self-checking bench for i2c_target_regfile
module tb_i2c_target_regfile;
  localparam int NREG = 16;
  localparam int PW   = 4;
  localparam int Q    = 6;

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] ptr_byte;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
    int         i0;
    int         i1;
    logic [7:0] v0;
    logic [7:0] v1;
  } wvec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  i2c_target_regfile_if #(.PW(PW)) ifc ();
  assign ifc.scl    = m_scl;
  assign ifc.sda_in = m_sda & ~ifc.sda_oe;

  i2c_target_regfile #(.DEV_ADDR(7'h27), .NREG(NREG), .SYNC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] wr_log [$];
  int            oe_cnt = 0;
  int            busy_cnt = 0;
  always @(negedge clk) begin
    if (ifc.wr_strobe) wr_log.push_back(ifc.wr_addr);
    if (ifc.sda_oe) oe_cnt++;
    if (ifc.busy) busy_cnt++;
  end

  logic [7:0] m_regs [NREG];
  int         m_ptr = 0;
  int         exp_wr [$];
  int         wr_rd = 0;
  logic [7:0] dq [$];
  logic [7:0] rd_q [$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_rd(input int a, output logic [7:0] d);
    ifc.host_addr = PW'(a);
    #1;
    d = ifc.host_rdata;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b;    tick(Q);
    m_scl = 1'b1; tick(Q);
    s = ifc.sda_in;
    tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
  endtask

  // Reference: pointer is taken mod NREG, each written byte lands at ptr then ptr advances
  task automatic mdl_write(input logic [7:0] p);
    m_ptr = int'(p) % NREG;
    foreach (dq[k]) begin
      m_regs[m_ptr] = dq[k];
      exp_wr.push_back(m_ptr);
      m_ptr = (m_ptr + 1) % NREG;
    end
  endtask

  task automatic chk_wr();
    int n;
    n = wr_log.size() - wr_rd;
    chk("wr_strobe_count", n, exp_wr.size());
    for (int k = 0; k < n && k < exp_wr.size(); k++) chk("wr_addr", wr_log[wr_rd + k], exp_wr[k]);
    wr_rd = wr_log.size();
    exp_wr.delete();
  endtask

  task automatic xfer_write(input logic [7:0] p);
    logic a;
    i2c_start();
    wr_byte(8'h4E, a); chk("wr_addr_ack", a, 1);
    wr_byte(p, a);     chk("wr_ptr_ack", a, 1);
    foreach (dq[k]) begin
      wr_byte(dq[k], a); chk("wr_data_ack", a, 1);
    end
    i2c_stop();
    tick(4);
    mdl_write(p);
    chk_wr();
  endtask

  task automatic xfer_read(input logic set_ptr, input logic [7:0] p, input int n);
    logic a;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      wr_byte(8'h4E, a); chk("rd_setup_addr_ack", a, 1);
      wr_byte(p, a);     chk("rd_setup_ptr_ack", a, 1);
      m_ptr = int'(p) % NREG;
      i2c_start();
    end
    wr_byte(8'h4F, a); chk("rd_addr_ack", a, 1);
    for (int k = 0; k < n; k++) begin
      rd_byte(k == n - 1, d);
      chk("rd_data", d, m_regs[m_ptr]);
      rd_q.push_back(d);
      if (k < n - 1) m_ptr = (m_ptr + 1) % NREG;
    end
    i2c_stop();
    tick(4);
    chk("rd_busy_after_stop", ifc.busy, 0);
    chk_wr();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wvec_t      vt [4];
    logic       a0, a1, a2, a3, s;
    logic [7:0] d;
    int         oe0, busy0, n;

    vt[0] = '{8'h4E, 8'h03, 8'hA5, 8'h5A, 1'b1, 3,  4, 8'hA5, 8'h5A};
    vt[1] = '{8'h4E, 8'h0F, 8'h11, 8'h22, 1'b1, 15, 0, 8'h11, 8'h22};
    vt[2] = '{8'h50, 8'h05, 8'h99, 8'h88, 1'b0, 5,  6, 8'h00, 8'h00};
    vt[3] = '{8'h4E, 8'h23, 8'hC3, 8'h3C, 1'b1, 3,  4, 8'hC3, 8'h3C};

    ifc.host_we = 1'b0; ifc.host_addr = '0; ifc.host_wdata = 8'h00;
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    rst = 1'b1; tick(3); rst = 1'b0; tick(2);

    chk("reset_sda_oe", ifc.sda_oe, 0);
    chk("reset_busy", ifc.busy, 0);
    chk("reset_wr_strobe", ifc.wr_strobe, 0);
    for (int i = 0; i < NREG; i++) begin
      host_rd(i, d);
      chk("reset_reg", d, 8'h00);
    end

    for (int v = 0; v < 4; v++) begin
      oe0 = oe_cnt; busy0 = busy_cnt;
      i2c_start();
      wr_byte(vt[v].addr_byte, a0);
      wr_byte(vt[v].ptr_byte, a1);
      wr_byte(vt[v].d0, a2);
      wr_byte(vt[v].d1, a3);
      i2c_stop();
      tick(4);
      chk("vec_addr_ack", a0, vt[v].exp_ack);
      chk("vec_data_acks", {a1, a2, a3}, vt[v].exp_ack ? 3'b111 : 3'b000);
      chk("vec_sda_oe_activity", oe_cnt != oe0, vt[v].exp_ack);
      chk("vec_busy_activity", busy_cnt != busy0, vt[v].exp_ack);
      chk("vec_busy_after_stop", ifc.busy, 0);
      host_rd(vt[v].i0, d); chk("vec_reg_i0", d, vt[v].v0);
      host_rd(vt[v].i1, d); chk("vec_reg_i1", d, vt[v].v1);
      dq.delete();
      if (vt[v].exp_ack) begin
        dq.push_back(vt[v].d0);
        dq.push_back(vt[v].d1);
      end
      mdl_write(vt[v].ptr_byte);
      chk_wr();
    end

    // Pointer write, repeated START, then a two-byte read ending in NACK
    dq.delete(); dq.push_back(8'hA5); dq.push_back(8'h5A);
    xfer_write(8'h03);
    rd_q.delete();
    xfer_read(1'b1, 8'h03, 2);
    chk("sr_read_byte0", rd_q[0], 8'hA5);
    chk("sr_read_byte1", rd_q[1], 8'h5A);

    // Host write to index 3 coincides with the I2C write; later host write to 9 coincides with index 4
    fork
      begin
        i2c_start();
        wr_byte(8'h4E, a0); wr_byte(8'h03, a1); wr_byte(8'hA5, a2); wr_byte(8'h5A, a3);
        i2c_stop();
      end
      begin
        ifc.host_we = 1'b1; ifc.host_addr = 4'd3; ifc.host_wdata = 8'h77;
        n = 0;
        while (!ifc.wr_strobe && n < 3000) begin @(negedge clk); n++; end
        chk("collision_strobe1_seen", ifc.wr_strobe, 1);
        ifc.host_addr = 4'd9; ifc.host_wdata = 8'h66;
        @(negedge clk);
        n = 0;
        while (!ifc.wr_strobe && n < 3000) begin @(negedge clk); n++; end
        chk("collision_strobe2_seen", ifc.wr_strobe, 1);
        ifc.host_we = 1'b0;
      end
    join
    tick(4);
    chk("collision_acks", {a0, a1, a2, a3}, 4'b1111);
    m_regs[9] = 8'h66;
    dq.delete(); dq.push_back(8'hA5); dq.push_back(8'h5A);
    mdl_write(8'h03);
    chk_wr();
    host_rd(3, d); chk("collision_reg3", d, 8'hA5);
    host_rd(4, d); chk("collision_reg4", d, 8'h5A);
    host_rd(9, d); chk("collision_reg9", d, 8'h66);

    // Reset while the target is driving bit 4 (a 0) of 0xA5
    i2c_start();
    wr_byte(8'h4E, a0); wr_byte(8'h03, a1);
    i2c_start();
    wr_byte(8'h4F, a2);
    chk("rst_rd_acks", {a0, a1, a2}, 3'b111);
    for (int k = 0; k < 3; k++) clk_bit(1'b1, s);
    chk("rst_rd_bit4_driven", ifc.sda_oe, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rd_sda_released", ifc.sda_oe, 0);
    chk("rst_rd_busy", ifc.busy, 0);
    @(negedge clk); rst = 1'b0;
    host_rd(3, d); chk("rst_rd_regs_cleared", d, 8'h00);
    m_scl = 1'b1; m_sda = 1'b1; tick(10);
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    wr_rd = wr_log.size();
    dq.delete(); dq.push_back(8'hBE);
    xfer_write(8'h02);
    host_rd(2, d); chk("rst_rd_after_write", d, 8'hBE);

    for (int t = 0; t < 20; t++) begin
      int kind, len;
      logic [7:0] p;
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 4);
      p    = 8'($urandom);
      if (kind <= 1) begin
        dq.delete();
        for (int k = 0; k < len; k++) dq.push_back(8'($urandom));
        xfer_write(p);
      end else if (kind == 2) begin
        xfer_read(1'b1, p, len);
      end else begin
        ifc.host_we = 1'b1; ifc.host_addr = PW'(p); ifc.host_wdata = 8'($urandom);
        m_regs[int'(p) % NREG] = ifc.host_wdata;
        @(negedge clk);
        ifc.host_we = 1'b0;
        xfer_read(1'b0, 8'h00, len);
      end
    end

    for (int i = 0; i < NREG; i++) begin
      host_rd(i, d);
      chk("final_reg", d, m_regs[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h27, the 7-bit target address.
REQ-002 SHALL have parameter NREG, default 16, the number of 8-bit registers (2..256); PW = $clog2(NREG).
REQ-003 SHALL have parameter SYNC, default 2, the synchronizer depth for scl/sda (>=2).
REQ-004 SHALL have port clk, input, 1 bit: single system clock, required >= 10x the SCL frequency.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port scl, input, 1 bit: I2C clock from the bus.
REQ-007 SHALL have port sda_in, input, 1 bit: I2C data sampled from the bus.
REQ-008 SHALL have port sda_oe, output, 1 bit: 1 = pull SDA low, 0 = release; the top level makes the pad open-drain.
REQ-009 SHALL have ports host_we (input, 1), host_addr (input, PW), host_wdata (input, 8) and host_rdata (output, 8): local register port.
REQ-010 SHALL have port wr_strobe, output, 1 bit: one-cycle pulse per register written from I2C.
REQ-011 SHALL have port wr_addr, output, PW bits: the register index written on wr_strobe.
REQ-012 SHALL have port busy, output, 1 bit: high from an addressed START up to the next STOP or START.

Function
REQ-013 SHALL pass scl and sda_in through SYNC flops each, then detect edges on the synchronized values; all logic runs on clk.
REQ-014 SHALL detect START as synchronized SDA 1->0 while SCL is high, and STOP as SDA 0->1 while SCL is high.
REQ-015 SHALL honor a START or STOP in any state, overriding other transitions in the same cycle.
REQ-016 SHALL implement the FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-017 SHALL go to ADDR on START, from any state; this includes a repeated START.
REQ-018 SHALL go to IDLE on STOP.
REQ-019 SHALL shift data bits MSB-first on each synchronized SCL rising edge.
REQ-020 SHALL use a 3-bit bit counter and treat the 8th rising edge as byte complete.
REQ-021 SHALL handle the address byte as follows: if bits[7:1] == DEV_ADDR, go to ADDR_ACK and latch rw = bit0; otherwise go to IGNORE (sda_oe held 0).
REQ-022 SHALL drive the ACK by setting sda_oe = 1 one clk after the SCL falling edge that follows bit 8, and clearing it one clk after the next SCL falling edge.
REQ-023 SHALL, after ADDR_ACK with rw = 0, enter PTR; the received byte is loaded into the pointer as byte mod NREG, then PTR_ACK.
REQ-024 SHALL, in the write path, have PTR_ACK -> WDATA; each WDATA byte writes reg[ptr], pulses wr_strobe with wr_addr = ptr, ACKs, and sets ptr = (ptr+1) mod NREG.
REQ-025 SHALL, after ADDR_ACK with rw = 1, enter RDATA and load the shift register with reg[ptr] at ACK release.
REQ-026 SHALL, in RDATA, drive sda_oe = ~bit one clk after each SCL falling edge, MSB first, and release after bit 0.
REQ-027 SHALL, in RDATA_ACK, sample the master's bit on the SCL rising edge: ACK(0) -> ptr++ and reload the next byte; NACK(1) -> IGNORE until STOP/START.
REQ-028 SHALL wrap ptr from NREG-1 to 0 in both directions.
REQ-029 SHALL keep ptr across repeated START, so a write pointer then Sr+read reads from that pointer.
REQ-030 SHALL return host_rdata = reg[host_addr] combinationally.
REQ-031 SHALL apply host_we on the clk edge.
REQ-032 SHALL let an I2C write win when it coincides with host_we to the same index; host writes to other indices both complete.
REQ-033 SHALL leave a byte unwritten and the FSM in ADDR if the byte is interrupted by a START.
REQ-034 SHALL leave a byte unwritten and the FSM in IDLE if the byte is interrupted by a STOP.
REQ-035 SHALL never drive sda_oe in IDLE or IGNORE.

Reset
REQ-036 SHALL, while rst = 1 at a clk edge, set state = IDLE, sda_oe = 0, wr_strobe = 0, busy = 0, ptr = 0, bit counter = 0, synchronizers = 1 (bus idle), and all registers = 8'h00.
REQ-037 SHALL abort any transfer on reset mid-transaction, releasing SDA within 1 clk; the block waits for a new START.

Verification
REQ-038 SHALL cover write: START, 0x4E, 0x03, 0xA5, 0x5A, STOP -> ACK on all 4 bytes, reg[3] = A5, reg[4] = 5A, two wr_strobe pulses with wr_addr 3 then 4.
REQ-039 SHALL cover read via Sr: START, 0x4E, 0x03, Sr, 0x4F, read 2 bytes (ACK, NACK), STOP -> SDA returns A5, 5A; FSM in IDLE after STOP.
REQ-040 SHALL cover address mismatch: START, 0x50, data, STOP -> sda_oe stays 0 throughout, no wr_strobe, busy stays 0.
REQ-041 SHALL cover wrap: NREG = 16, pointer 0x0F, write 0x11, 0x22 -> reg[15] = 11, reg[0] = 22.
REQ-042 SHALL cover collision: host_we to index 3 with 0x77 in the same clk as the I2C write of 0xA5 to index 3 -> reg[3] = A5.
REQ-043 SHALL cover reset mid-read: assert rst during bit 4 of RDATA -> sda_oe = 0 next clk, state IDLE, registers = 00, next START is served normally.
